writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 104 ++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bundle: memory-stage result handshake, decode issue port, regfile write port,
// condition codes and the per-register pending scoreboard view.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_load_regfile;
  logic        in_load_cc;
  logic [2:0]  in_dest;
  logic [1:0]  in_wbsel;
  logic [15:0] in_alu;
  logic [15:0] in_mem;
  logic [15:0] in_pc;
  logic        in_addr0;
  logic        wb_hold;
  logic        issue_valid;
  logic        issue_writes;
  logic [2:0]  issue_dest;
  logic [2:0]  write_register;
  logic [15:0] write_data;
  logic        load_regfile;
  logic [2:0]  nzp;
  logic [7:0]  pending;
  logic        issue_stall;

  modport slave (
    input  in_valid, in_load_regfile, in_load_cc, in_dest, in_wbsel,
           in_alu, in_mem, in_pc, in_addr0, wb_hold,
           issue_valid, issue_writes, issue_dest,
    output in_ready, write_register, write_data, load_regfile, nzp,
           pending, issue_stall
  );

  modport master (
    output in_valid, in_load_regfile, in_load_cc, in_dest, in_wbsel,
           in_alu, in_mem, in_pc, in_addr0, wb_hold,
           issue_valid, issue_writes, issue_dest,
    input  in_ready, write_register, write_data, load_regfile, nzp,
           pending, issue_stall
  );
endinterface

// File: rtl/writeback_stage.sv
// lc3b writeback: selects/registers the result (latency 1) and tracks outstanding writes per register.
// wb_hold stalls intake (in_ready low) and freezes the output register with the write enable masked.
module writeback_stage #(
  parameter int NUM_REGS     = 8,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  writeback_stage_if.slave   wb
);
  localparam logic [1:0] LP_MAX = 2'(MAX_INFLIGHT);

  logic                w_xfer;
  logic                w_inc;
  logic                w_dec;
  logic                w_stall;
  logic [7:0]          w_byte;
  logic [15:0]         w_sel_data;
  logic [2:0]          w_nzp;
  logic [NUM_REGS-1:0] w_inc_vec;
  logic [NUM_REGS-1:0] w_dec_vec;

  logic [1:0]          r_count [NUM_REGS];
  logic [2:0]          r_write_register;
  logic [15:0]         r_write_data;
  logic                r_load_regfile;
  logic [2:0]          r_nzp;

  assign w_xfer = wb.in_valid && !wb.wb_hold;
  assign w_dec  = w_xfer && wb.in_load_regfile;

  // A retiring write to the same register frees a slot in the same cycle.
  assign w_stall = wb.issue_valid && wb.issue_writes &&
                   (r_count[wb.issue_dest] == LP_MAX) &&
                   !(w_dec && (wb.in_dest == wb.issue_dest));
  assign w_inc   = wb.issue_valid && wb.issue_writes && !w_stall;

  always_comb begin
    w_byte     = wb.in_addr0 ? wb.in_mem[15:8] : wb.in_mem[7:0];
    w_sel_data = wb.in_alu;
    case (wb.in_wbsel)
      2'b00:   w_sel_data = wb.in_alu;
      2'b01:   w_sel_data = wb.in_mem;
      2'b10:   w_sel_data = {{8{w_byte[7]}}, w_byte};
      default: w_sel_data = wb.in_pc;
    endcase
    w_nzp = {w_sel_data[15], (w_sel_data == 16'h0000),
             !w_sel_data[15] && (w_sel_data != 16'h0000)};
  end

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc_vec[i] = w_inc && (wb.issue_dest == 3'(i));
      w_dec_vec[i] = w_dec && (wb.in_dest == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!reset_n) begin
        r_count[i] <= 2'd0;
      end else if (w_inc_vec[i] && !w_dec_vec[i] && (r_count[i] != LP_MAX)) begin
        r_count[i] <= r_count[i] + 2'd1;
      end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_count[i] != 2'd0)) begin
        r_count[i] <= r_count[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_write_register <= 3'd0;
      r_write_data     <= 16'h0000;
      r_load_regfile   <= 1'b0;
      r_nzp            <= 3'b000;
    end else if (w_xfer) begin
      r_write_register <= wb.in_dest;
      r_write_data     <= w_sel_data;
      r_load_regfile   <= wb.in_load_regfile;
      if (wb.in_load_cc) begin
        r_nzp <= w_nzp;
      end
    end else if (!wb.wb_hold) begin
      r_load_regfile <= 1'b0;
    end
  end

  always_comb begin
    wb.pending = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb.pending[i] = (r_count[i] != 2'd0);
    end
  end

  // The enable is masked rather than cleared so a frozen write resumes intact after hold.
  assign wb.in_ready       = !wb.wb_hold;
  assign wb.load_regfile   = r_load_regfile && !wb.wb_hold;
  assign wb.write_register = r_write_register;
  assign wb.write_data     = r_write_data;
  assign wb.nzp            = r_nzp;
  assign wb.issue_stall    = w_stall;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every regfile write.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2:0] model_nzp = 3'b000;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic [2:0]  nzp;
  } exp_t;
  exp_t sb[$];

  writeback_stage_if u_if();

  writeback_stage #(.NUM_REGS(8), .MAX_INFLIGHT(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.load_regfile === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got reg %0d data %h expected no write",
                 u_if.write_register, u_if.write_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_reg", 16'(u_if.write_register), 16'(e.rd));
        chk("wr_data", u_if.write_data, e.data);
        chk("wr_nzp", 16'(u_if.nzp), 16'(e.nzp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.in_valid = 1'b0;
    u_if.in_load_regfile = 1'b0;
    u_if.in_load_cc = 1'b0;
    u_if.in_dest = 3'd0;
    u_if.in_wbsel = 2'b00;
    u_if.in_alu = 16'h0;
    u_if.in_mem = 16'h0;
    u_if.in_pc = 16'h0;
    u_if.in_addr0 = 1'b0;
    u_if.wb_hold = 1'b0;
    u_if.issue_valid = 1'b0;
    u_if.issue_writes = 1'b0;
    u_if.issue_dest = 3'd0;
  endtask

  task automatic issue(input logic [2:0] d);
    u_if.issue_valid = 1'b1;
    u_if.issue_writes = 1'b1;
    u_if.issue_dest = d;
  endtask

  task automatic set_wb(input logic [2:0] d, input logic [1:0] sel, input logic [15:0] alu,
                        input logic [15:0] mem, input logic [15:0] pc, input logic a0,
                        input logic cc);
    u_if.in_valid = 1'b1;
    u_if.in_load_regfile = 1'b1;
    u_if.in_load_cc = cc;
    u_if.in_dest = d;
    u_if.in_wbsel = sel;
    u_if.in_alu = alu;
    u_if.in_mem = mem;
    u_if.in_pc = pc;
    u_if.in_addr0 = a0;
  endtask

  task automatic expect_wb(input logic [2:0] d, input logic [15:0] data, input logic cc);
    exp_t e;
    if (cc) model_nzp = {data[15], data == 16'h0, !data[15] && (data != 16'h0)};
    e.rd = d;
    e.data = data;
    e.nzp = model_nzp;
    sb.push_back(e);
  endtask

  task automatic wb(input logic [2:0] d, input logic [1:0] sel, input logic [15:0] alu,
                    input logic [15:0] mem, input logic [15:0] pc, input logic a0,
                    input logic cc, input logic [15:0] exp_data);
    set_wb(d, sel, alu, mem, pc, a0, cc);
    expect_wb(d, exp_data, cc);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    step();
    step();
    chk("rst_load", 16'(u_if.load_regfile), 16'd0);
    chk("rst_wreg", 16'(u_if.write_register), 16'd0);
    chk("rst_wdata", u_if.write_data, 16'h0000);
    chk("rst_nzp", 16'(u_if.nzp), 16'd0);
    chk("rst_pending", 16'(u_if.pending), 16'h00);
    chk("rst_ready", 16'(u_if.in_ready), 16'd1);
    u_if.wb_hold = 1'b1;
    #1;
    chk("rst_ready_hold", 16'(u_if.in_ready), 16'd0);
    u_if.wb_hold = 1'b0;
    reset_n = 1'b1;
    step();

    // Data-select vectors, back to back.
    wb(3'd3, 2'b00, 16'h8001, 16'h0, 16'h0, 1'b0, 1'b1, 16'h8001); step();
    wb(3'd4, 2'b10, 16'h0, 16'h7F80, 16'h0, 1'b0, 1'b1, 16'hFF80); step();
    wb(3'd4, 2'b10, 16'h0, 16'h7F80, 16'h0, 1'b1, 1'b1, 16'h007F); step();
    wb(3'd0, 2'b01, 16'h0, 16'h1234, 16'h0, 1'b0, 1'b1, 16'h1234); step();
    wb(3'd7, 2'b10, 16'h0, 16'h0012, 16'h0, 1'b1, 1'b1, 16'h0000); step();
    wb(3'd6, 2'b11, 16'h0, 16'h0, 16'hABCD, 1'b0, 1'b0, 16'hABCD); step();
    idle();
    step();
    chk("idle_load", 16'(u_if.load_regfile), 16'd0);
    chk("idle_wdata", u_if.write_data, 16'hABCD);
    chk("idle_wreg", 16'(u_if.write_register), 16'd6);
    chk("idle_nzp", 16'(u_if.nzp), 16'(3'b010));

    // Scoreboard saturation on R5.
    for (int k = 0; k < 3; k++) begin
      issue(3'd5);
      #1;
      chk("issue_nostall", 16'(u_if.issue_stall), 16'd0);
      step();
    end
    idle();
    #1;
    chk("pending_r5", 16'(u_if.pending), 16'h20);
    issue(3'd5);
    #1;
    chk("stall_full", 16'(u_if.issue_stall), 16'd1);
    step();
    wb(3'd5, 2'b00, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0005);
    #1;
    chk("stall_bypass", 16'(u_if.issue_stall), 16'd0);
    step();
    idle();
    issue(3'd5);
    #1;
    chk("stall_still_full", 16'(u_if.issue_stall), 16'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      wb(3'd5, 2'b00, 16'h0010 + 16'(k), 16'h0, 16'h0, 1'b0, 1'b0, 16'h0010 + 16'(k));
      step();
      idle();
      #1;
      chk("drain_pending", 16'(u_if.pending), (k < 2) ? 16'h20 : 16'h00);
    end

    // Hold with a valid result waiting.
    issue(3'd6);
    step();
    idle();
    #1;
    chk("hold_pre_pending", 16'(u_if.pending), 16'h40);
    u_if.wb_hold = 1'b1;
    set_wb(3'd6, 2'b00, 16'h0042, 16'h0, 16'h0, 1'b0, 1'b1);
    #1;
    chk("hold_ready", 16'(u_if.in_ready), 16'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("hold_load", 16'(u_if.load_regfile), 16'd0);
      chk("hold_pending", 16'(u_if.pending), 16'h40);
      chk("hold_wreg", 16'(u_if.write_register), 16'd5);
    end
    u_if.wb_hold = 1'b0;
    expect_wb(3'd6, 16'h0042, 1'b1);
    step();
    idle();
    #1;
    chk("release_pending", 16'(u_if.pending), 16'h00);
    step();

    // Reset while a transfer is presented.
    issue(3'd1);
    step();
    step();
    idle();
    #1;
    chk("pre_rst_pending", 16'(u_if.pending), 16'h02);
    set_wb(3'd1, 2'b00, 16'h8000, 16'h0, 16'h0, 1'b0, 1'b1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    idle();
    model_nzp = 3'b000;
    #1;
    chk("mid_rst_pending", 16'(u_if.pending), 16'h00);
    chk("mid_rst_load", 16'(u_if.load_regfile), 16'd0);
    chk("mid_rst_nzp", 16'(u_if.nzp), 16'd0);
    chk("mid_rst_wdata", u_if.write_data, 16'h0000);
    step();

    // Writeback to a register with nothing outstanding.
    wb(3'd2, 2'b00, 16'h0222, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0222);
    step();
    idle();
    #1;
    chk("underflow_pending", 16'(u_if.pending), 16'h00);
    issue(3'd2);
    step();
    idle();
    #1;
    chk("after_underflow_issue", 16'(u_if.pending), 16'h04);
    wb(3'd2, 2'b00, 16'h0202, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0202);
    step();
    idle();
    #1;
    chk("final_pending", 16'(u_if.pending), 16'h00);
    step();
    step();
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
